// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss arbiter slice.
package cache_pkg;

  localparam int unsigned DATA_W            = 16;
  localparam int unsigned BLOCK_OFFSET_BITS = 4;
  localparam int unsigned WORDS_PER_BLOCK   = 8;
  localparam int unsigned WORD_IDX_W        = $clog2(WORDS_PER_BLOCK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;

endpackage

// File: rtl/cache_miss_arbiter_fill_counter.sv
// Small word counter used to track issued and received block words.
module fill_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  // Count events; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

  // Flag the last index so the next event completes the block.
  assign done = (count == '1);

endmodule

// File: rtl/cache_miss_arbiter.sv
// Miss handler between the split caches and the shared pipelined main memory.
// Arbitrates D-miss > D-store > I-miss, fetches whole blocks and drives stalls.
module cache_miss_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ic_miss,
  input  logic [ADDR_W-1:0]     ic_miss_addr,
  input  logic                  dc_miss,
  input  logic [ADDR_W-1:0]     dc_miss_addr,
  input  logic                  dc_wr_req,
  input  logic [ADDR_W-1:0]     dc_wr_addr,
  input  logic [DATA_W-1:0]     dc_wr_data,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_data_valid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [DATA_W-1:0]     fill_data,
  output logic [WORD_IDX_W-1:0] fill_word,
  output logic                  ic_fill_we,
  output logic                  dc_fill_we,
  output logic                  ic_tag_we,
  output logic                  dc_tag_we,
  output logic [ADDR_W-1:0]     tag_addr,
  output logic                  dc_wr_ack,
  output logic                  ic_stall,
  output logic                  dc_stall
);

  state_t                  state;
  owner_t                  owner;
  logic [ADDR_W-1:0]       base;

  logic [WORD_IDX_W-1:0]   issued;
  logic [WORD_IDX_W-1:0]   received;
  logic                    issuedDone;
  logic                    receivedDone;

  logic                    idle;
  logic                    grantDc;
  logic                    grantIc;
  logic                    storeGo;
  logic                    issueGo;
  logic                    returnGo;
  logic                    lastIssue;
  logic                    lastReturn;
  logic                    clrCnt;

  // Arbitration and per-cycle event decode.
  always_comb begin
    idle       = (state == IDLE);
    grantDc    = idle & dc_miss;
    storeGo    = idle & ~dc_miss & dc_wr_req;
    grantIc    = idle & ~dc_miss & ~dc_wr_req & ic_miss;
    issueGo    = (state == FILL);
    returnGo   = ~idle & mem_data_valid;
    lastIssue  = issueGo & issuedDone;
    lastReturn = returnGo & receivedDone;
    clrCnt     = grantDc | grantIc | lastReturn;
  end

  fill_counter #(.WIDTH(WORD_IDX_W)) issuedCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clrCnt),
    .inc   (issueGo),
    .count (issued),
    .done  (issuedDone)
  );

  fill_counter #(.WIDTH(WORD_IDX_W)) receivedCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clrCnt),
    .inc   (returnGo),
    .count (received),
    .done  (receivedDone)
  );

  // Block-fill sequencer: latch owner and block base on grant, return to IDLE on the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= OWN_IC;
      base  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantDc) begin
            state <= FILL;
            owner <= OWN_DC;
            base  <= {dc_miss_addr[ADDR_W-1:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
          end else if (grantIc) begin
            state <= FILL;
            owner <= OWN_IC;
            base  <= {ic_miss_addr[ADDR_W-1:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
          end
        end
        FILL: begin
          if (lastReturn) begin
            state <= IDLE;
          end else if (lastIssue) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (lastReturn) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from state and inputs so store acks and fill writes land in the request cycle.
  always_comb begin
    mem_enable = storeGo | issueGo;
    mem_wr     = storeGo;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (storeGo) begin
      mem_addr  = dc_wr_addr;
      mem_wdata = dc_wr_data;
    end else if (issueGo) begin
      mem_addr = base + ADDR_W'({issued, 1'b0});
    end

    dc_wr_ack  = storeGo;

    fill_data  = returnGo ? mem_rdata : '0;
    fill_word  = returnGo ? received : '0;
    ic_fill_we = returnGo & (owner == OWN_IC);
    dc_fill_we = returnGo & (owner == OWN_DC);
    ic_tag_we  = lastReturn & (owner == OWN_IC);
    dc_tag_we  = lastReturn & (owner == OWN_DC);
    tag_addr   = lastReturn ? base : '0;

    ic_stall   = ic_miss | (~idle & (owner == OWN_IC));
    dc_stall   = dc_miss | (dc_wr_req & ~storeGo) | (~idle & (owner == OWN_DC));
  end

endmodule

// File: tb/tb_cache_miss_arbiter.sv
// Self-checking bench for cache_miss_arbiter with a pipelined memory model and
// a transaction-level reference of the block-fill rules.
module tb_cache_miss_arbiter;

  localparam int MEM_LATENCY = 4;
  localparam int WORDS       = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_miss;
  logic [15:0] ic_miss_addr;
  logic        dc_miss;
  logic [15:0] dc_miss_addr;
  logic        dc_wr_req;
  logic [15:0] dc_wr_addr;
  logic [15:0] dc_wr_data;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_data_valid;
  logic [15:0] mem_rdata;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        ic_fill_we;
  logic        dc_fill_we;
  logic        ic_tag_we;
  logic        dc_tag_we;
  logic [15:0] tag_addr;
  logic        dc_wr_ack;
  logic        ic_stall;
  logic        dc_stall;

  always #5 clk = ~clk;

  cache_miss_arbiter #(.ADDR_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ic_miss        (ic_miss),
    .ic_miss_addr   (ic_miss_addr),
    .dc_miss        (dc_miss),
    .dc_miss_addr   (dc_miss_addr),
    .dc_wr_req      (dc_wr_req),
    .dc_wr_addr     (dc_wr_addr),
    .dc_wr_data     (dc_wr_data),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_data_valid (mem_data_valid),
    .mem_rdata      (mem_rdata),
    .fill_data      (fill_data),
    .fill_word      (fill_word),
    .ic_fill_we     (ic_fill_we),
    .dc_fill_we     (dc_fill_we),
    .ic_tag_we      (ic_tag_we),
    .dc_tag_we      (dc_tag_we),
    .tag_addr       (tag_addr),
    .dc_wr_ack      (dc_wr_ack),
    .ic_stall       (ic_stall),
    .dc_stall       (dc_stall)
  );

  typedef struct packed {
    logic        memEnable;
    logic        memWr;
    logic [15:0] memAddr;
    logic [15:0] memWdata;
    logic [15:0] fillData;
    logic [2:0]  fillWord;
    logic        icFillWe;
    logic        dcFillWe;
    logic        icTagWe;
    logic        dcTagWe;
    logic [15:0] tagAddr;
    logic        dcWrAck;
    logic        icStall;
    logic        dcStall;
  } outs_t;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } rd_t;

  rd_t   rdQ[$];
  int    cyc;
  int    nCompared;
  int    nMismatched;
  outs_t obs;
  outs_t expd;
  logic  holdMem;

  // Reference: one outstanding block transaction described by owner, base, grant cycle, words received.
  bit          mBusy;
  bit          mOwnDc;
  logic [15:0] mBase;
  int          mGrant;
  int          mRecv;

  // Memory contents: odd multiplier makes every address map to a distinct word.
  function automatic logic [15:0] memWord(input logic [15:0] a);
    return (a * 16'd40503) ^ 16'h1234;
  endfunction

  // One clock: drive memory return, sample DUT, predict, advance model, release served requesters.
  task automatic tick();
    rd_t r;
    int  age;
    bit  ack;
    bit  relIc;
    bit  relDc;
    mem_data_valid = 1'b0;
    mem_rdata      = '0;
    if (rdQ.size() > 0 && !holdMem) begin
      if (rdQ[0].due <= cyc) begin
        r = rdQ.pop_front();
        mem_data_valid = 1'b1;
        mem_rdata      = memWord(r.addr);
      end
    end
    #2;
    obs = {mem_enable, mem_wr, mem_addr, mem_wdata, fill_data, fill_word, ic_fill_we,
           dc_fill_we, ic_tag_we, dc_tag_we, tag_addr, dc_wr_ack, ic_stall, dc_stall};

    if (!rst_n) mBusy = 0;
    expd = '0;
    age  = cyc - mGrant;
    ack  = !mBusy && !dc_miss && dc_wr_req;
    if (ack) begin
      expd.memEnable = 1'b1;
      expd.memWr     = 1'b1;
      expd.memAddr   = dc_wr_addr;
      expd.memWdata  = dc_wr_data;
      expd.dcWrAck   = 1'b1;
    end
    if (mBusy && age >= 1 && age <= WORDS) begin
      expd.memEnable = 1'b1;
      expd.memAddr   = mBase + 16'(2 * (age - 1));
    end
    if (mBusy && mem_data_valid) begin
      expd.fillData = memWord(mBase + 16'(2 * mRecv));
      expd.fillWord = 3'(mRecv);
      if (mOwnDc) expd.dcFillWe = 1'b1; else expd.icFillWe = 1'b1;
      if (mRecv == WORDS - 1) begin
        expd.tagAddr = mBase;
        if (mOwnDc) expd.dcTagWe = 1'b1; else expd.icTagWe = 1'b1;
      end
    end
    expd.icStall = ic_miss | (mBusy & !mOwnDc);
    expd.dcStall = dc_miss | (dc_wr_req & !ack) | (mBusy & mOwnDc);

    if (mem_enable && !mem_wr) begin
      r.addr = mem_addr;
      r.due  = cyc + MEM_LATENCY;
      rdQ.push_back(r);
    end

    if (rst_n) begin
      if (mBusy) begin
        if (mem_data_valid) begin
          mRecv++;
          if (mRecv == WORDS) mBusy = 0;
        end
      end else if (dc_miss) begin
        mBusy = 1; mOwnDc = 1; mBase = dc_miss_addr & 16'hFFF0; mGrant = cyc; mRecv = 0;
      end else if (!dc_wr_req && ic_miss) begin
        mBusy = 1; mOwnDc = 0; mBase = ic_miss_addr & 16'hFFF0; mGrant = cyc; mRecv = 0;
      end
    end

    relIc = expd.icTagWe;
    relDc = expd.dcTagWe;
    @(posedge clk);
    #1;
    cyc++;
    if (relIc) ic_miss = 1'b0;
    if (relDc) dc_miss = 1'b0;
    if (ack) dc_wr_req = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    ic_miss = 0; dc_miss = 0; dc_wr_req = 0; holdMem = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    outs_t want;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      want = '0;
      if (i == 1) begin
        ic_miss = 1'b1; ic_miss_addr = 16'h0123; want.icStall = 1'b1;
      end else begin
        ic_miss = 1'b0;
      end
      if (i == 2) rst_n = 1'b1;
      tick();
      nCompared++;
      if (obs !== want) begin
        nMismatched++;
        $display("FAIL reset_outputs[%0d]: got %h required %h", i, obs, want);
      end
      nCompared++;
      if (obs !== expd) begin
        nMismatched++;
        $display("FAIL reset_model[%0d]: got %h required %h", i, obs, expd);
      end
    end
  endtask

  task automatic test_ic_miss();
    ic_miss = 1'b1; ic_miss_addr = 16'h0036;
    for (int i = 0; i < 14; i++) begin
      if (i == 4) ic_miss_addr = 16'($urandom);
      tick();
      nCompared++;
      if (obs !== expd) begin
        nMismatched++;
        $display("FAIL ic_miss_cycle%0d: got %h required %h", i, obs, expd);
      end
      if (i == 1 || i == 8) begin
        nCompared++;
        if (!(obs.memEnable === 1'b1 && obs.memWr === 1'b0 &&
              obs.memAddr === (i == 1 ? 16'h0030 : 16'h003E))) begin
          nMismatched++;
          $display("FAIL ic_read_addr[%0d]: got en=%b addr=%h required read of %h", i,
                   obs.memEnable, obs.memAddr, (i == 1 ? 16'h0030 : 16'h003E));
        end
      end
      if (i >= 5 && i <= 12) begin
        nCompared++;
        if (obs.icFillWe !== 1'b1 || obs.fillWord !== 3'(i - 5)) begin
          nMismatched++;
          $display("FAIL ic_fill_word[%0d]: got we=%b word=%0d required we=1 word=%0d", i,
                   obs.icFillWe, obs.fillWord, i - 5);
        end
      end
      if (i == 12) begin
        nCompared++;
        if (obs.icTagWe !== 1'b1 || obs.tagAddr !== 16'h0030) begin
          nMismatched++;
          $display("FAIL ic_tag: got we=%b addr=%h required we=1 addr=0030", obs.icTagWe, obs.tagAddr);
        end
      end
      if (i == 13) begin
        nCompared++;
        if (obs.icStall !== 1'b0) begin
          nMismatched++;
          $display("FAIL ic_stall_release: got %b required 0", obs.icStall);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    ic_miss = 1'b1; ic_miss_addr = 16'h0100;
    dc_miss = 1'b1; dc_miss_addr = 16'h2008;
    for (int i = 0; i < 27; i++) begin
      tick();
      nCompared++;
      if (obs !== expd) begin
        nMismatched++;
        $display("FAIL simul_cycle%0d: got %h required %h", i, obs, expd);
      end
      if (i <= 25) begin
        nCompared++;
        if (obs.icStall !== 1'b1) begin
          nMismatched++;
          $display("FAIL simul_ic_stall[%0d]: got %b required 1", i, obs.icStall);
        end
      end
      if (i == 12) begin
        nCompared++;
        if (obs.dcTagWe !== 1'b1 || obs.icTagWe !== 1'b0 || obs.tagAddr !== 16'h2000) begin
          nMismatched++;
          $display("FAIL simul_dc_tag: got dc=%b ic=%b addr=%h required dc=1 ic=0 addr=2000",
                   obs.dcTagWe, obs.icTagWe, obs.tagAddr);
        end
      end
      if (i == 14) begin
        nCompared++;
        if (obs.memEnable !== 1'b1 || obs.memAddr !== 16'h0100) begin
          nMismatched++;
          $display("FAIL simul_ic_first_read: got en=%b addr=%h required en=1 addr=0100",
                   obs.memEnable, obs.memAddr);
        end
      end
    end
  endtask

  task automatic test_store_then_miss();
    logic [15:0] missAddr;
    missAddr = 16'($urandom);
    dc_wr_req = 1'b1; dc_wr_addr = 16'h1002; dc_wr_data = 16'hBEEF;
    tick();
    nCompared++;
    if (obs.memEnable !== 1'b1 || obs.memWr !== 1'b1 || obs.memAddr !== 16'h1002 ||
        obs.memWdata !== 16'hBEEF || obs.dcWrAck !== 1'b1) begin
      nMismatched++;
      $display("FAIL store_issue: got en=%b wr=%b addr=%h data=%h ack=%b required 1 1 1002 beef 1",
               obs.memEnable, obs.memWr, obs.memAddr, obs.memWdata, obs.dcWrAck);
    end
    dc_miss = 1'b1; dc_miss_addr = missAddr;
    for (int i = 1; i < 15; i++) begin
      tick();
      nCompared++;
      if (obs !== expd) begin
        nMismatched++;
        $display("FAIL store_miss_cycle%0d: got %h required %h", i, obs, expd);
      end
      if (i == 2) begin
        nCompared++;
        if (obs.memEnable !== 1'b1 || obs.memWr !== 1'b0 || obs.memAddr !== (missAddr & 16'hFFF0)) begin
          nMismatched++;
          $display("FAIL store_miss_first_read: got en=%b wr=%b addr=%h required 1 0 %h",
                   obs.memEnable, obs.memWr, obs.memAddr, missAddr & 16'hFFF0);
        end
      end
    end
  endtask

  task automatic test_store_during_fill();
    logic [15:0] sAddr;
    logic [15:0] sData;
    sAddr = 16'($urandom);
    sData = 16'($urandom);
    ic_miss = 1'b1; ic_miss_addr = 16'($urandom);
    for (int i = 0; i < 15; i++) begin
      if (i == 3) begin
        dc_wr_req = 1'b1; dc_wr_addr = sAddr; dc_wr_data = sData;
      end
      tick();
      nCompared++;
      if (obs !== expd) begin
        nMismatched++;
        $display("FAIL store_fill_cycle%0d: got %h required %h", i, obs, expd);
      end
      if (i >= 3 && i <= 12) begin
        nCompared++;
        if (obs.memWr !== 1'b0 || obs.dcWrAck !== 1'b0 || obs.dcStall !== 1'b1) begin
          nMismatched++;
          $display("FAIL store_held[%0d]: got wr=%b ack=%b stall=%b required 0 0 1", i,
                   obs.memWr, obs.dcWrAck, obs.dcStall);
        end
      end
      if (i == 13) begin
        nCompared++;
        if (obs.dcWrAck !== 1'b1 || obs.memWr !== 1'b1 || obs.memAddr !== sAddr || obs.memWdata !== sData) begin
          nMismatched++;
          $display("FAIL store_after_fill: got ack=%b wr=%b addr=%h data=%h required 1 1 %h %h",
                   obs.dcWrAck, obs.memWr, obs.memAddr, obs.memWdata, sAddr, sData);
        end
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    dc_miss = 1'b1; dc_miss_addr = 16'($urandom);
    for (int i = 0; i < 21; i++) begin
      if (i == 6) begin
        rst_n = 1'b0; dc_miss = 1'b0;
      end
      if (i == 8) rst_n = 1'b1;
      tick();
      nCompared++;
      if (obs !== expd) begin
        nMismatched++;
        $display("FAIL rst_fill_cycle%0d: got %h required %h", i, obs, expd);
      end
      if (i == 5) begin
        nCompared++;
        if (obs.dcFillWe !== 1'b1 || obs.fillWord !== 3'd0) begin
          nMismatched++;
          $display("FAIL rst_fill_first_word: got we=%b word=%0d required we=1 word=0",
                   obs.dcFillWe, obs.fillWord);
        end
      end
      if (i >= 6) begin
        nCompared++;
        if (obs !== outs_t'(0)) begin
          nMismatched++;
          $display("FAIL rst_fill_quiet[%0d]: got %h required all zero", i, obs);
        end
      end
    end
  endtask

  task automatic test_gaps();
    int nFill;
    nFill = 0;
    ic_miss = 1'b1; ic_miss_addr = 16'hFFF7;
    for (int i = 0; i < 18; i++) begin
      holdMem = (i == 7 || i == 9);
      tick();
      nCompared++;
      if (obs !== expd) begin
        nMismatched++;
        $display("FAIL gap_cycle%0d: got %h required %h", i, obs, expd);
      end
      if (i == 8) begin
        nCompared++;
        if (obs.memAddr !== 16'hFFFE) begin
          nMismatched++;
          $display("FAIL gap_last_read: got %h required fffe", obs.memAddr);
        end
      end
      if (i == 7 || i == 9) begin
        nCompared++;
        if (obs.icFillWe !== 1'b0) begin
          nMismatched++;
          $display("FAIL gap_hold[%0d]: got fill_we=%b required 0", i, obs.icFillWe);
        end
      end
      if (obs.icFillWe === 1'b1) begin
        nCompared++;
        if (obs.fillWord !== 3'(nFill) || obs.icTagWe !== (nFill == 7)) begin
          nMismatched++;
          $display("FAIL gap_sequence[%0d]: got word=%0d tag=%b required word=%0d tag=%b", i,
                   obs.fillWord, obs.icTagWe, nFill, (nFill == 7));
        end
        nFill++;
      end
    end
    holdMem = 1'b0;
    nCompared++;
    if (nFill != WORDS) begin
      nMismatched++;
      $display("FAIL gap_word_count: got %0d required %0d", nFill, WORDS);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (!ic_miss && $urandom_range(0, 9) == 0) begin
        ic_miss = 1'b1; ic_miss_addr = 16'($urandom);
      end else if (ic_miss && $urandom_range(0, 7) == 0) begin
        ic_miss_addr = 16'($urandom);
      end
      if (!dc_miss && $urandom_range(0, 11) == 0) begin
        dc_miss = 1'b1; dc_miss_addr = 16'($urandom);
      end else if (dc_miss && $urandom_range(0, 7) == 0) begin
        dc_miss_addr = 16'($urandom);
      end
      if (!dc_wr_req && $urandom_range(0, 4) == 0) begin
        dc_wr_req = 1'b1; dc_wr_addr = 16'($urandom); dc_wr_data = 16'($urandom);
      end
      holdMem = ($urandom_range(0, 3) == 0);
      tick();
      nCompared++;
      if (obs !== expd) begin
        nMismatched++;
        $display("FAIL random_cycle%0d: got %h required %h", i, obs, expd);
      end
    end
    ic_miss = 0; dc_miss = 0; dc_wr_req = 0; holdMem = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      nCompared++;
      if (obs !== expd) begin
        nMismatched++;
        $display("FAIL random_drain%0d: got %h required %h", i, obs, expd);
      end
    end
  endtask

  initial begin
    nCompared = 0; nMismatched = 0; cyc = 0; holdMem = 1'b0;
    mBusy = 0; mOwnDc = 0; mBase = '0; mGrant = 0; mRecv = 0;
    rst_n = 1'b1;
    ic_miss = 0; ic_miss_addr = '0;
    dc_miss = 0; dc_miss_addr = '0;
    dc_wr_req = 0; dc_wr_addr = '0; dc_wr_data = '0;
    mem_data_valid = 0; mem_rdata = '0;
    #1;
    test_reset();
    idle_gap(4);
    test_ic_miss();
    idle_gap(8);
    test_simultaneous();
    idle_gap(8);
    test_store_then_miss();
    idle_gap(8);
    test_store_during_fill();
    idle_gap(8);
    test_reset_mid_fill();
    idle_gap(8);
    test_gaps();
    idle_gap(8);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
